// File: rtl/cube_pkg.sv
// Shared LED-cube chain definitions: word geometry and the tagged word
// type exchanged between the chain receiver and readback consumers.
package cube_pkg;

    localparam int CHAIN_WORD_WIDTH = 16;
    localparam int CHAIN_LEN        = 16;
    localparam int CHAIN_IDX_W      = $clog2(CHAIN_LEN);

    // One received chain word and its position in the chain (0 = first word received).
    typedef struct packed {
        logic [CHAIN_WORD_WIDTH-1:0] data;
        logic [CHAIN_IDX_W-1:0]      index;
    } chain_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush. A pop in the same cycle as a push on a
// full FIFO frees the slot, so the push is accepted. Pop on empty is ignored.
module sync_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    // Effective pop/push: pop only with data present; push only with room (or a freeing pop).
    always_comb begin
        empty  = (r_count == '0);
        full   = (r_count == (AW+1)'(DEPTH));
        w_pop  = pop && !empty;
        w_push = push && (!full || w_pop);
        dout   = r_mem[r_rd_ptr];
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage; cleared on reset so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!flush && w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/serial_chain_receiver.sv
// Receive end of the LED-driver serial chain. Deserializes the looped-back
// SDO stream MSB-first into words, tags each with its chain position and
// buffers them for a valid/ready consumer.
// Handshake: word_valid means the FIFO head (word_data/word_index) is valid;
// it is consumed on the clk edge where word_valid & word_ready are both 1.
module serial_chain_receiver #(
    parameter int WIDTH      = cube_pkg::CHAIN_WORD_WIDTH,
    parameter int CHAIN_LEN  = cube_pkg::CHAIN_LEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_start,
    input  logic                         shift,
    input  logic                         ser_in,
    output logic [WIDTH-1:0]             word_data,
    output logic [$clog2(CHAIN_LEN)-1:0] word_index,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         busy,
    output logic                         dbg_state
);

    localparam int IDX_W = $clog2(CHAIN_LEN);
    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_sreg;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [IDX_W-1:0] r_word_cnt;
    logic             r_overflow;
    logic             r_frame_done;

    logic                   w_shift_en;
    logic                   w_word_done;
    logic                   w_last_word;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [WIDTH-1:0]       w_word;
    logic [WIDTH+IDX_W-1:0] w_fifo_dout;

    // Shift qualification, word completion and next-state; frame_start overrides shift.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = (r_state == S_RECV) && shift && !frame_start;
        w_word_done = w_shift_en && (r_bit_cnt == BIT_W'(WIDTH-1));
        w_last_word = w_word_done && (r_word_cnt == IDX_W'(CHAIN_LEN-1));
        w_word      = {r_sreg[WIDTH-2:0], ser_in};
        w_pop       = word_ready && !w_empty;
        if (frame_start) begin
            w_state_nxt = S_RECV;
        end else if (w_last_word) begin
            w_state_nxt = S_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Shift register, bit/word counters, sticky overflow and frame_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (frame_start) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_word;
            if (w_shift_en) begin
                r_sreg <= w_word;
                if (w_word_done) begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= w_last_word ? '0 : r_word_cnt + IDX_W'(1);
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
            end
            if (w_word_done && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Completed words are written on the edge that samples their last bit.
    sync_fifo #(
        .DATA_W (WIDTH + IDX_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (frame_start),
        .push    (w_word_done),
        .pop     (word_ready),
        .din     ({w_word, r_word_cnt}),
        .dout    (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Output mapping.
    always_comb begin
        word_data  = w_fifo_dout[WIDTH+IDX_W-1:IDX_W];
        word_index = w_fifo_dout[IDX_W-1:0];
        word_valid = !w_empty;
        frame_done = r_frame_done;
        overflow   = r_overflow;
        busy       = (r_state == S_RECV);
        dbg_state  = r_state;
    end

endmodule

// File: tb/tb_serial_chain_receiver.sv
// Bench for serial_chain_receiver: scenario tasks with inline checks plus a
// scoreboard monitor comparing every consumed word against an expected queue.
module tb_serial_chain_receiver;
    import cube_pkg::*;

    localparam int WIDTH = CHAIN_WORD_WIDTH;
    localparam int IDX_W = CHAIN_IDX_W;
    localparam int W     = WIDTH + IDX_W;

    logic             clk;
    logic             reset_n;
    logic             frame_start;
    logic             shift;
    logic             ser_in;
    logic [WIDTH-1:0] word_data;
    logic [IDX_W-1:0] word_index;
    logic             word_valid;
    logic             word_ready;
    logic             frame_done;
    logic             overflow;
    logic             busy;
    logic             dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    serial_chain_receiver #(
        .WIDTH      (WIDTH),
        .CHAIN_LEN  (CHAIN_LEN),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .shift       (shift),
        .ser_in      (ser_in),
        .word_data   (word_data),
        .word_index  (word_index),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got data=%h index=%0d, expected no word", word_data, word_index);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({word_data, word_index} !== e) begin
                    failures++;
                    $display("FAIL sb_word: got data=%h index=%0d, expected data=%h index=%0d",
                             word_data, word_index, e[W-1:IDX_W], e[IDX_W-1:0]);
                end
            end
        end
    end

    // Driver helpers.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic [IDX_W-1:0] idx,
                             input bit exp_push, input bit ready_last);
        for (int b = WIDTH - 1; b >= 0; b--) begin
            shift  = 1'b1;
            ser_in = d[b];
            if (b == 0) begin
                if (ready_last) word_ready = 1'b1;
                if (exp_push) exp_q.push_back({d, idx});
            end
            step();
        end
        shift  = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        shift       = 1'b0;
        ser_in      = 1'b0;
        word_ready  = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", word_valid); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL rst_state: got %b expected 0", dbg_state); end
        checks++; if (word_data !== '0 || word_index !== '0) begin failures++; $display("FAIL rst_head: got %h/%0d expected 0/0", word_data, word_index); end
    endtask

    task automatic test_single_word();
        word_ready = 1'b1;
        pulse_frame_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start: got %b expected 1", busy); end
        send_word(16'hA5C3, 4'd0, 1'b1, 1'b0);
        checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", word_valid); end
        checks++; if (word_data !== 16'hA5C3) begin failures++; $display("FAIL single_data: got %h expected a5c3", word_data); end
        checks++; if (word_index !== 4'd0) begin failures++; $display("FAIL single_index: got %0d expected 0", word_index); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
        step();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL single_consumed: got %b expected 0", word_valid); end
    endtask

    task automatic test_full_frame();
        word_ready = 1'b1;
        pulse_frame_start();
        for (int k = 0; k < CHAIN_LEN; k++) begin
            send_word(WIDTH'(16'h0100 + k), IDX_W'(k), 1'b1, 1'b0);
            checks++;
            if (frame_done !== (k == CHAIN_LEN - 1)) begin
                failures++;
                $display("FAIL frame_done_word%0d: got %b expected %b", k, frame_done, (k == CHAIN_LEN - 1));
            end
        end
        step();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL frame_done_pulse: got %b expected 0", frame_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
        send_word(16'hDEAD, 4'd0, 1'b0, 1'b0);
        step();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL idle_shift_ignored: got %b expected 0", word_valid); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL frame_all_received: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        pulse_frame_start();
        for (int k = 0; k < 5; k++) begin
            send_word(WIDTH'(16'h3000 + k), IDX_W'(k), (k < 4), 1'b0);
            if (k == 3) begin
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL ovf_held: got %b expected 1", word_valid); end
        word_ready = 1'b1;
        repeat (6) step();
        checks++; if (word_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain: got valid=%b pending=%0d expected 0/0", word_valid, exp_q.size()); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        pulse_frame_start();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_with_pop();
        word_ready = 1'b0;
        pulse_frame_start();
        for (int k = 0; k < 4; k++) send_word(WIDTH'(16'h4A00 + k), IDX_W'(k), 1'b1, 1'b0);
        send_word(16'h4A04, 4'd4, 1'b1, 1'b1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
        repeat (6) step();
        checks++; if (word_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL fullpop_drain: got valid=%b pending=%0d expected 0/0", word_valid, exp_q.size()); end
    endtask

    task automatic test_abort();
        word_ready = 1'b0;
        pulse_frame_start();
        send_word(16'h1234, 4'd0, 1'b0, 1'b0);
        for (int b = 0; b < 7; b++) begin
            shift  = 1'b1;
            ser_in = 1'b1;
            step();
        end
        frame_start = 1'b1;
        shift       = 1'b1;
        ser_in      = 1'b0;
        step();
        frame_start = 1'b0;
        shift       = 1'b0;
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL abort_flush: got %b expected 0", word_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b expected 1", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_frame_done: got %b expected 0", frame_done); end
        word_ready = 1'b1;
        send_word(16'hFFFF, 4'd0, 1'b1, 1'b0);
        checks++; if (word_data !== 16'hFFFF || word_index !== 4'd0) begin failures++; $display("FAIL abort_next: got %h/%0d expected ffff/0", word_data, word_index); end
        step();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL abort_consumed: got %b expected 0", word_valid); end
    endtask

    task automatic test_async_reset();
        word_ready = 1'b0;
        pulse_frame_start();
        send_word(16'h5A5A, 4'd0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            shift  = 1'b1;
            ser_in = 1'b1;
            step();
        end
        shift = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL areset_flags: got valid=%b busy=%b ovf=%b done=%b expected 0", word_valid, busy, overflow, frame_done);
        end
        checks++; if (word_data !== '0 || word_index !== '0) begin failures++; $display("FAIL areset_head: got %h/%0d expected 0/0", word_data, word_index); end
        repeat (2) step();
        reset_n    = 1'b1;
        word_ready = 1'b1;
        step();
        send_word(16'h0F0F, 4'd0, 1'b0, 1'b0);
        step();
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL areset_idle_shift: got valid=%b busy=%b expected 0/0", word_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_overflow();
        test_full_with_pop();
        test_abort();
        test_async_reset();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
